// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state encoding and default sizing for the scanning channel mux
package mux_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Default channel geometry
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NCH   = 4;

endpackage

// File: rtl/mux_nx1_comb.sv
// rtl/mux_nx1_comb.sv - combinational N-to-1 channel selector, zero for out-of-range index
module mux_nx1_comb #(
  parameter int WIDTH = mux_pkg::DEF_WIDTH,
  parameter int NCH   = mux_pkg::DEF_NCH,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      idx,
  output logic [WIDTH-1:0]     dout
);

  // Pick channel idx; indices with no matching channel fall through to zero
  always_comb begin
    dout = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SELW'(k)) begin
        dout = din[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered channel mux with manual select and one-shot scan; MUX_PARITY_EN adds zpar
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  input  logic                 start,
  output logic [WIDTH-1:0]     zout,
  output logic [SELW-1:0]      zch,
  output logic                 zvalid,
  output logic                 busy,
`ifdef MUX_PARITY_EN
  output logic                 zpar,
`endif
  output logic                 done
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [1:0]       state_q, state_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] zout_q, zout_d;
  logic [SELW-1:0]  zch_q, zch_d;
  logic             zvalid_q, zvalid_d;
  logic             done_q, done_d;
  logic             load;
  logic [SELW-1:0]  mux_idx;
  logic [WIDTH-1:0] mux_dout;
  logic             sel_in_range;

  // The scan counter drives the selector while scanning, the manual select otherwise
  always_comb begin
    mux_idx = (state_q == SCAN) ? cnt_q : sel;
  end

  mux_nx1_comb #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .SELW  (SELW)
  ) u_sel (
    .din  (din),
    .idx  (mux_idx),
    .dout (mux_dout)
  );

  assign sel_in_range = (int'(sel) < NCH);

  // Next-state and output-register loading for IDLE / SCAN / DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    zout_d   = zout_q;
    zch_d    = zch_q;
    zvalid_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          load     = 1'b1;
          zout_d   = mux_dout;
          zch_d    = sel;
          zvalid_d = sel_in_range;
        end else if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        load     = 1'b1;
        zout_d   = mux_dout;
        zch_d    = cnt_q;
        zvalid_d = 1'b1;
        if (cnt_q == LAST_CH) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SELW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      zout_q   <= '0;
      zch_q    <= '0;
      zvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      zout_q   <= zout_d;
      zch_q    <= zch_d;
      zvalid_q <= zvalid_d;
      done_q   <= done_d;
    end
  end

`ifdef MUX_PARITY_EN
  logic zpar_q, zpar_d;

  // Even parity tracks whatever value is loaded into zout in the same cycle
  always_comb begin
    zpar_d = zpar_q;
    if (load) begin
      zpar_d = ^zout_d;
    end
  end

  // Parity register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zpar_q <= 1'b0;
    end else begin
      zpar_q <= zpar_d;
    end
  end

  assign zpar = zpar_q;
`endif

  assign zout   = zout_q;
  assign zch    = zch_q;
  assign zvalid = zvalid_q;
  assign busy   = (state_q == SCAN);
  assign done   = done_q;

endmodule
